// File: rtl/z80mini_pkg.sv
// z80mini_pkg
//   Shared definitions for the Z80 bank mapper slice: default IO port base,
//   default reset page map, control-register bit positions, wait-counter
//   width and the wait-state FSM encoding.
package z80mini_pkg;

    localparam logic [7:0]  DEF_IO_BASE   = 8'hF0;

    // Page 0 lives in the least significant slice.
    localparam logic [23:0] DEF_RESET_MAP = {6'h22, 6'h21, 6'h20, 6'h00};

    // ctrl[0] = 1 suppresses all wait states (reset value 0 means waits are on).
    // ctrl[1] = 1 overrides every per-page write protect bit.
    localparam int CTRL_WAIT_OFF = 0;
    localparam int CTRL_WP_OFF   = 1;

    localparam int WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } wait_state_t;

endpackage

// File: rtl/z80_wait_gen.sv
// z80_wait_gen
//   Wait-state generator. Holds nWAIT asserted for n clk0 strobes once a
//   qualifying bus cycle starts, then parks in HOLD until the CPU drops its
//   request so the same M-cycle is not waited twice.
// Ports
//   clk       in   1           system clock
//   nRESET    in   1           synchronous, active-low reset
//   clk0      in   1           CPU-clock-aligned strobe qualifying all bus sampling
//   start     in   1           current bus cycle wants wait states
//   active    in   1           MREQ or IORQ is currently asserted
//   n         in   WAIT_CNT_W  number of wait states for this cycle (0 = none)
//   wait_drv  out  1           1 = pull nWAIT low
module z80_wait_gen
    import z80mini_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRESET,
    input  logic                  clk0,
    input  logic                  start,
    input  logic                  active,
    input  logic [WAIT_CNT_W-1:0] n,
    output logic                  wait_drv
);

    wait_state_t           state, state_nx;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Counter is loaded with n-1 so that wait_drv is seen low by the CPU on
    // exactly n clk0 strobes. Losing the bus strobes aborts without waiting
    // for clk0, so a cut-short cycle never leaves nWAIT pulled.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wait_drv = 1'b0;
        case (state)
            IDLE: begin
                if (clk0 && start && (n != '0)) begin
                    state_nx = COUNT;
                    cnt_nx   = n - WAIT_CNT_W'(1);
                end
            end
            COUNT: begin
                wait_drv = 1'b1;
                if (!active) begin
                    state_nx = IDLE;
                end else if (clk0) begin
                    if (cnt == '0) begin
                        state_nx = HOLD;
                    end else begin
                        cnt_nx = cnt - WAIT_CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!active) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/z80_bank_mapper.sv
// z80_bank_mapper
//   Z80 memory bank mapper. 2**PAGE_BITS page registers translate the top
//   address bits of the CPU into a PHYS_W-bit physical page. Adds per-page
//   write protect with fault reporting and wait states for slow physical
//   pages and IO cycles.
// Ports
//   CLK50MHz    in   1          system clock
//   nRESET      in   1          synchronous, active-low reset
//   clk0        in   1          CPU-clock-aligned strobe qualifying bus sampling
//   A           in   16         CPU address bus
//   d_in        in   8          CPU write data
//   nMREQ, nIORQ, nRD, nWR, nM1 in 1   CPU bus strobes
//   ext_a       out  PHYS_W     physical page of the current access
//   d_out       out  8          register readback data
//   d_oe        out  1          drive d_out onto the CPU bus
//   wait_drv    out  1          1 = pull nWAIT low
//   mem_we      out  1          gated memory write strobe
//   wr_fault    out  1          single-cycle pulse per blocked write
//   fault_page  out  PAGE_BITS  CPU page index of the last blocked write
module z80_bank_mapper
    import z80mini_pkg::*;
#(
    parameter int                                 PAGE_BITS  = 2,
    parameter int                                 PHYS_W     = 6,
    parameter logic [7:0]                         IO_BASE    = DEF_IO_BASE,
    parameter logic [PHYS_W*(2**PAGE_BITS)-1:0]   RESET_MAP  = DEF_RESET_MAP,
    parameter logic [PHYS_W-1:0]                  SLOW_MASK  = 6'h30,
    parameter logic [PHYS_W-1:0]                  SLOW_MATCH = 6'h10,
    parameter int                                 MEM_WAIT   = 2,
    parameter int                                 IO_WAIT    = 1
) (
    input  logic                 CLK50MHz,
    input  logic                 nRESET,
    input  logic                 clk0,
    input  logic [15:0]          A,
    input  logic [7:0]           d_in,
    input  logic                 nMREQ,
    input  logic                 nIORQ,
    input  logic                 nRD,
    input  logic                 nWR,
    input  logic                 nM1,
    output logic [PHYS_W-1:0]    ext_a,
    output logic [7:0]           d_out,
    output logic                 d_oe,
    output logic                 wait_drv,
    output logic                 mem_we,
    output logic                 wr_fault,
    output logic [PAGE_BITS-1:0] fault_page
);

    localparam int NPAGES = 2 ** PAGE_BITS;

    logic [PHYS_W-1:0]     page [NPAGES];
    logic [NPAGES-1:0]     wp;
    logic [1:0]            ctrl;
    logic                  fault_done;

    logic [PAGE_BITS-1:0]  cur;
    logic [7:0]            io_off;
    logic                  page_hit;
    logic                  ctrl_hit;
    logic                  io_wr;
    logic                  blocked_wr;
    logic                  mem_slow_req;
    logic                  io_wait_req;
    logic                  wait_start;
    logic                  bus_active;
    logic [WAIT_CNT_W-1:0] wait_n;
    logic                  unused_bits;

    assign cur      = A[15 -: PAGE_BITS];
    assign io_off   = A[7:0] - IO_BASE;
    assign page_hit = (io_off < 8'(NPAGES));
    assign ctrl_hit = (io_off == 8'(NPAGES));
    assign io_wr    = clk0 & ~nIORQ & ~nWR & nM1;

    assign unused_bits = &{1'b0, A, d_in};

    // Page/protect/control registers. Written by OUT to IO_BASE+i (page i)
    // or IO_BASE+NPAGES (ctrl); bit 7 of the data is the write-protect flag.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            for (int i = 0; i < NPAGES; i++) begin
                page[i] <= RESET_MAP[i*PHYS_W +: PHYS_W];
            end
            wp   <= '0;
            ctrl <= '0;
        end else if (io_wr) begin
            if (page_hit) begin
                page[io_off[PAGE_BITS-1:0]] <= d_in[PHYS_W-1:0];
                wp[io_off[PAGE_BITS-1:0]]   <= d_in[7];
            end else if (ctrl_hit) begin
                ctrl <= d_in[1:0];
            end
        end
    end

    // Readback selects the page by the upper address byte, so IN r,(C)
    // with B holding the CPU address of interest reads that page's mapping.
    always_comb begin
        d_out = 8'hFF;
        if (page_hit) begin
            d_out[PHYS_W-1:0] = page[cur];
            d_out[7]          = wp[cur];
        end else if (ctrl_hit) begin
            d_out = {6'b0, ctrl};
        end
    end

    assign d_oe   = ~nIORQ & ~nRD & nM1 & (page_hit | ctrl_hit);
    assign ext_a  = page[cur];

    assign blocked_wr = ~nMREQ & ~nWR & wp[cur] & ~ctrl[CTRL_WP_OFF];
    assign mem_we     = ~nMREQ & ~nWR & ~(wp[cur] & ~ctrl[CTRL_WP_OFF]);

    // One pulse per blocked write: fault_done stays set for the rest of the
    // write strobe so a long or wait-stretched write reports only once.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            wr_fault   <= 1'b0;
            fault_page <= '0;
            fault_done <= 1'b0;
        end else begin
            wr_fault <= 1'b0;
            if (nWR) begin
                fault_done <= 1'b0;
            end else if (clk0 && blocked_wr && !fault_done) begin
                wr_fault   <= 1'b1;
                fault_page <= cur;
                fault_done <= 1'b1;
            end
        end
    end

    // Interrupt acknowledge (nM1 low with nIORQ) is never stretched.
    assign mem_slow_req = ~nMREQ & ((ext_a & SLOW_MASK) == SLOW_MATCH) & (MEM_WAIT > 0);
    assign io_wait_req  = ~nIORQ & nM1 & (IO_WAIT > 0);
    assign wait_start   = (mem_slow_req | io_wait_req) & ~ctrl[CTRL_WAIT_OFF];
    assign bus_active   = ~nMREQ | ~nIORQ;
    assign wait_n       = mem_slow_req ? WAIT_CNT_W'(MEM_WAIT) : WAIT_CNT_W'(IO_WAIT);

    z80_wait_gen u_wait_gen (
        .clk      (CLK50MHz),
        .nRESET   (nRESET),
        .clk0     (clk0),
        .start    (wait_start),
        .active   (bus_active),
        .n        (wait_n),
        .wait_drv (wait_drv)
    );

endmodule

// File: tb/tb_z80_bank_mapper.sv
// tb_z80_bank_mapper
//   Directed bench for z80_bank_mapper. Stimulus pushes expected values into
//   a scoreboard queue and raises chk_req; a separate monitor counts wait
//   strobes / fault pulses and pops and compares the queue on the next
//   falling edge.
module tb_z80_bank_mapper;

    localparam int SIG_EXT     = 0;
    localparam int SIG_DOUT    = 1;
    localparam int SIG_DOE     = 2;
    localparam int SIG_WAIT    = 3;
    localparam int SIG_WE      = 4;
    localparam int SIG_FAULT   = 5;
    localparam int SIG_FPAGE   = 6;
    localparam int SIG_PULSES  = 7;
    localparam int SIG_STROBES = 8;

    typedef struct {
        string name;
        int    sig;
        int    val;
    } exp_t;

    logic        CLK50MHz;
    logic        nRESET;
    logic        clk0;
    logic [15:0] A;
    logic [7:0]  d_in;
    logic        nMREQ, nIORQ, nRD, nWR, nM1;
    logic [5:0]  ext_a;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        wait_drv;
    logic        mem_we;
    logic        wr_fault;
    logic [1:0]  fault_page;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   wait_strobes;
    int   fault_pulses;
    logic chk_req;
    int   phase;

    logic [7:0] exp_rd  [4];
    logic [5:0] exp_ext [4];

    z80_bank_mapper dut (
        .CLK50MHz   (CLK50MHz),
        .nRESET     (nRESET),
        .clk0       (clk0),
        .A          (A),
        .d_in       (d_in),
        .nMREQ      (nMREQ),
        .nIORQ      (nIORQ),
        .nRD        (nRD),
        .nWR        (nWR),
        .nM1        (nM1),
        .ext_a      (ext_a),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .wait_drv   (wait_drv),
        .mem_we     (mem_we),
        .wr_fault   (wr_fault),
        .fault_page (fault_page)
    );

    initial begin
        CLK50MHz = 1'b0;
        forever #10 CLK50MHz = ~CLK50MHz;
    end

    // clk0 is high for one system cycle out of every four.
    initial begin
        clk0  = 1'b0;
        phase = 0;
        forever begin
            @(posedge CLK50MHz);
            #1;
            phase = (phase + 1) % 4;
            clk0  = (phase == 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int actual(input int s);
        case (s)
            SIG_EXT:     return int'(ext_a);
            SIG_DOUT:    return int'(d_out);
            SIG_DOE:     return int'(d_oe);
            SIG_WAIT:    return int'(wait_drv);
            SIG_WE:      return int'(mem_we);
            SIG_FAULT:   return int'(wr_fault);
            SIG_FPAGE:   return int'(fault_page);
            SIG_PULSES:  return fault_pulses;
            SIG_STROBES: return wait_strobes;
            default:     return -1;
        endcase
    endfunction

    // Monitor: event counters first, then drain the scoreboard on request.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge CLK50MHz);
            if (clk0 && wait_drv) wait_strobes++;
            if (wr_fault) fault_pulses++;
            if (chk_req) begin
                while (sb.size() > 0) begin
                    e   = sb.pop_front();
                    act = actual(e.sig);
                    checks++;
                    if (act != e.val) begin
                        errors++;
                        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
                    end
                end
            end
        end
    end

    task automatic expect_sig(input string nm, input int sig, input int val);
        sb.push_back('{nm, sig, val});
    endtask

    task automatic checkOutput();
        chk_req = 1'b1;
        @(negedge CLK50MHz);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                                 input logic mreq, input logic iorq, input logic rd,
                                 input logic wr, input logic m1);
        A     = addr;
        d_in  = data;
        nMREQ = mreq;
        nIORQ = iorq;
        nRD   = rd;
        nWR   = wr;
        nM1   = m1;
    endtask

    task automatic clk0_edges(input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge CLK50MHz); while (clk0 !== 1'b1);
            #2;
        end
    endtask

    task automatic idle_bus();
        applyStimulus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge CLK50MHz);
        #2;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        applyStimulus(addr, data, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        clk0_edges(1);
        idle_bus();
    endtask

    initial begin
        int base;
        checks       = 0;
        errors       = 0;
        wait_strobes = 0;
        fault_pulses = 0;
        chk_req      = 1'b0;
        exp_rd       = '{8'h40, 8'h60, 8'h61, 8'h62};
        exp_ext      = '{6'h00, 6'h20, 6'h21, 6'h22};
        nRESET       = 1'b0;
        applyStimulus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset state
        repeat (3) @(posedge CLK50MHz);
        #2;
        expect_sig("reset_wait_drv", SIG_WAIT, 0);
        expect_sig("reset_wr_fault", SIG_FAULT, 0);
        expect_sig("reset_fault_page", SIG_FPAGE, 0);
        expect_sig("reset_d_oe", SIG_DOE, 0);
        expect_sig("reset_mem_we", SIG_WE, 0);
        checkOutput();
        nRESET = 1'b1;
        idle_bus();

        // Reset map readback, selected by A[15:14]
        for (int hi = 0; hi < 4; hi++) begin
            applyStimulus({hi[1:0], 6'b0, 8'hF0}, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            expect_sig($sformatf("rd_page%0d_d_out", hi), SIG_DOUT, int'(exp_rd[hi]));
            expect_sig($sformatf("rd_page%0d_d_oe", hi), SIG_DOE, 1);
            expect_sig($sformatf("rd_page%0d_ext_a", hi), SIG_EXT, int'(exp_ext[hi]));
            checkOutput();
            idle_bus();
        end
        applyStimulus(16'h00F4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_sig("rd_ctrl_reset", SIG_DOUT, 8'h00);
        expect_sig("rd_ctrl_d_oe", SIG_DOE, 1);
        checkOutput();
        idle_bus();

        // Write-protected page 2 remapped to 0x05
        io_write(16'h00F2, 8'h85);
        applyStimulus(16'h80F2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_sig("rd_page2_wp", SIG_DOUT, 8'hC5);
        checkOutput();
        idle_bus();
        base = fault_pulses;
        applyStimulus(16'h8000, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_sig("wp_ext_a", SIG_EXT, 6'h05);
        expect_sig("wp_mem_we_blocked", SIG_WE, 0);
        checkOutput();
        clk0_edges(3);
        expect_sig("wp_fault_pulse_count", SIG_PULSES, base + 1);
        expect_sig("wp_fault_page", SIG_FPAGE, 2);
        expect_sig("wp_fault_low_after", SIG_FAULT, 0);
        checkOutput();
        idle_bus();

        // Unprotected page 0 writes normally
        applyStimulus(16'h0010, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_sig("page0_mem_we", SIG_WE, 1);
        checkOutput();
        idle_bus();

        // Global write-protect disable
        io_write(16'h00F4, 8'h02);
        applyStimulus(16'h00F4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_sig("rd_ctrl_02", SIG_DOUT, 8'h02);
        checkOutput();
        idle_bus();
        base = fault_pulses;
        applyStimulus(16'h8000, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_sig("wpoff_mem_we", SIG_WE, 1);
        checkOutput();
        clk0_edges(3);
        expect_sig("wpoff_no_fault", SIG_PULSES, base);
        expect_sig("wpoff_fault_page_kept", SIG_FPAGE, 2);
        checkOutput();
        idle_bus();
        io_write(16'h00F4, 8'h00);

        // Slow memory: page 1 -> 0x10, two wait strobes then HOLD
        io_write(16'h00F1, 8'h10);
        base = wait_strobes;
        applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_sig("slow_ext_a", SIG_EXT, 6'h10);
        checkOutput();
        clk0_edges(1);
        expect_sig("slow_wait_asserted", SIG_WAIT, 1);
        checkOutput();
        clk0_edges(5);
        expect_sig("slow_wait_strobes", SIG_STROBES, base + 2);
        expect_sig("slow_hold_released", SIG_WAIT, 0);
        checkOutput();
        idle_bus();

        // IO read outside register range: one wait state, no drive
        base = wait_strobes;
        applyStimulus(16'h0008, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_sig("io08_d_oe", SIG_DOE, 0);
        expect_sig("io08_d_out", SIG_DOUT, 8'hFF);
        checkOutput();
        clk0_edges(4);
        expect_sig("io08_wait_strobes", SIG_STROBES, base + 1);
        checkOutput();
        idle_bus();

        // Interrupt acknowledge: no wait, no drive even at a register port
        base = wait_strobes;
        applyStimulus(16'h00F0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_sig("inta_d_oe", SIG_DOE, 0);
        checkOutput();
        clk0_edges(4);
        expect_sig("inta_wait_strobes", SIG_STROBES, base);
        checkOutput();
        idle_bus();

        // Waits globally disabled
        io_write(16'h00F4, 8'h01);
        base = wait_strobes;
        applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        clk0_edges(4);
        expect_sig("waitoff_strobes", SIG_STROBES, base);
        checkOutput();
        idle_bus();
        io_write(16'h00F4, 8'h00);

        // Reset while counting
        applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        clk0_edges(1);
        expect_sig("rstcnt_wait_before", SIG_WAIT, 1);
        checkOutput();
        nRESET = 1'b0;
        @(posedge CLK50MHz);
        #2;
        expect_sig("rstcnt_wait_cleared", SIG_WAIT, 0);
        expect_sig("rstcnt_page1_restored", SIG_EXT, 6'h20);
        expect_sig("rstcnt_fault_page", SIG_FPAGE, 0);
        checkOutput();
        applyStimulus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge CLK50MHz);
        #2;
        nRESET = 1'b1;
        idle_bus();
        applyStimulus(16'h80F0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_sig("rstcnt_page2_restored", SIG_DOUT, 8'h61);
        checkOutput();
        idle_bus();

        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
